mem_access_ctrl: RTL
====================

# mem_access_ctrl

Load/store controller between the core's memory stage and the single-port, read-first word BRAM holding program data. It accepts one byte-addressed request at a time over a valid/ready handshake and converts it to a word address. It sequences the BRAM's enable/write-enable around its one-cycle registered read latency, returns load data or a store acknowledge as a one-cycle response pulse, and flags out-of-range or misaligned accesses without touching the RAM. It also keeps free-running load/store counters for performance measurement.

## Interface
- ADDR_W, 16, word-address width of the BRAM (2^ADDR_W words)
- clk  in  1  clock; all logic on rising edge
- rstn  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; a request is accepted at an edge where req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- resp_valid  out  1  one-cycle response pulse; no backpressure
- resp_rdata  out  32  load data (0 for stores and faults)
- resp_fault  out  1  qualifies resp_valid: access rejected
- ram_en  out  1  BRAM enable
- ram_we  out  1  BRAM write enable
- ram_addr  out  32  BRAM word address, zero-extended from ADDR_W bits
- ram_di  out  32  BRAM write data
- ram_dout  in  32  BRAM read data, valid the cycle after the enable edge
- load_cnt  out  32  completed non-faulting loads, wraps at 2^32
- store_cnt  out  32  completed non-faulting stores, wraps at 2^32

## Operation
- The FSM has three states: IDLE, ISSUE, RDWAIT. req_ready = rstn && (state == IDLE).
- Address decode:
  - Word index = req_addr[ADDR_W+1:2].
  - Range fault if req_addr[31:ADDR_W+2] != 0.
  - The alignment fault is controlled by the macro described under Configuration.
- Accept while IDLE, faulting:
  - State stays IDLE. The next cycle has resp_valid=1, resp_fault=1, resp_rdata=0.
  - ram_en stays 0, and counters are unchanged.
- Accept while IDLE, good:
  - Register ram_addr, ram_di=req_wdata, ram_we=req_we, ram_en=1, and go to ISSUE.
- ISSUE (ram_en=1 for exactly this cycle):
  - Store: at the end edge, go to IDLE with resp_valid=1, resp_fault=0, resp_rdata=0, and store_cnt+1.
  - Load: go to RDWAIT.
- RDWAIT:
  - ram_en=0 and ram_we=0; ram_dout is valid.
  - At the end edge: resp_rdata <= ram_dout, resp_valid=1, load_cnt+1, go to IDLE.
- Outputs outside their states:
  - ram_en and ram_we are 0 in every state except ISSUE.
  - ram_addr and ram_di hold their last values.
  - resp_rdata holds its value until the next response.
- A new request is accepted in the same cycle a response pulse is visible, because the FSM is back in IDLE.

## Timing
- Reset values: state IDLE; resp_valid, resp_fault, ram_en, ram_we = 0; resp_rdata, ram_addr, ram_di, load_cnt, store_cnt = 0. req_ready = 0 while rstn=0.
- Latency, counted from the acceptance edge E0 to the edge after which resp_valid is high:
  - fault: 1 edge
  - store: 2 edges (RAM writes at E1)
  - load: 3 edges (RAM reads at E1, data captured at E2)
- Throughput: one store per 2 cycles, one load per 3 cycles, one fault per cycle.
- Reset mid-operation:
  - The RAM sees the enable driven during the reset cycle. A store in ISSUE therefore still writes memory.
  - No response is produced, and the FSM returns to IDLE.
- A counter increment coincident with reset is lost; reset wins.

## Configuration
- MEM_ALIGN_CHECK_EN defined: req_addr[1:0] != 0 is an alignment fault.
- MEM_ALIGN_CHECK_EN undefined: req_addr[1:0] is ignored, and only the range check applies.

## Structure
- Shared package mem_pkg holds:
  - the state enum (IDLE/ISSUE/RDWAIT)
  - the default MEM_ADDR_W = 16
  - the word-index slice constants
- Sub-module mem_addr_check (combinational) produces word index, range_fault and align_fault from req_addr. It is the only place that uses MEM_ALIGN_CHECK_EN.

## Test plan
- Store 0xDEADBEEF at byte address 0x100, then load 0x100:
  - Store: ram_we=1 with ram_addr=0x40 one cycle after acceptance; resp_valid 2 edges after acceptance.
  - Load: resp_rdata=0xDEADBEEF 3 edges after acceptance; store_cnt=1, load_cnt=1.
- Load 0x0004_0000 with ADDR_W=16: resp_fault=1 one edge after acceptance, ram_en never high, counters unchanged.
- Load 0x102:
  - MEM_ALIGN_CHECK_EN defined: fault.
  - Undefined: returns the word at index 0x40.
- Back-to-back: req_valid held with loads to 0x0, 0x4, 0x8. Acceptances 3 cycles apart, and each new acceptance coincides with the previous resp_valid.
- Drop rstn during the ISSUE of a store to 0x200:
  - No resp_valid; counters, resp and ram outputs reset to 0.
  - A subsequent load of 0x200 returns the stored data.
- Preload store_cnt near wrap (0xFFFFFFFF via 2^32-1 stores or a force), then issue one store: store_cnt = 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the load/store controller and its address checker.
// Holds the FSM state encoding, the default BRAM depth and the byte-to-word slice position.
package mem_pkg;

    localparam int MEM_ADDR_W = 16;

    // Byte address bits below WORD_LSB select a byte within a 32-bit word.
    localparam int WORD_LSB   = 2;
    localparam int DATA_W     = 32;
    localparam int BYTE_ADR_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2
    } mem_state_e;

    function automatic logic [DATA_W-1:0] cnt_inc(input logic [DATA_W-1:0] cnt);
        return cnt + {{(DATA_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Core-side request/response bundle: valid/ready request channel and a one-cycle response pulse.
// The controller uses the slave modport; the memory stage (or a bench) drives through master.
interface mem_access_ctrl_if;
    import mem_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [BYTE_ADR_W-1:0] req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic                  resp_valid;
    logic [DATA_W-1:0]     resp_rdata;
    logic                  resp_fault;

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output resp_valid,
        output resp_rdata,
        output resp_fault
    );

    modport master (
        output req_valid,
        output req_we,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  resp_valid,
        input  resp_rdata,
        input  resp_fault
    );

endinterface

// File: rtl/mem_addr_check.sv
// Combinational byte-address decode: word index, out-of-range flag and (with MEM_ALIGN_CHECK_EN) misalignment flag.
// Zero latency; no handshake. MEM_ALIGN_CHECK_EN undefined: low address bits are ignored.
module mem_addr_check
    import mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W
) (
    input  logic [BYTE_ADR_W-1:0] addr_i,
    output logic [ADDR_W-1:0]     word_idx_o,
    output logic                  range_fault_o,
    output logic                  align_fault_o
);

    assign word_idx_o    = addr_i[ADDR_W+WORD_LSB-1:WORD_LSB];
    assign range_fault_o = |addr_i[BYTE_ADR_W-1:ADDR_W+WORD_LSB];

`ifdef MEM_ALIGN_CHECK_EN
    assign align_fault_o = |addr_i[WORD_LSB-1:0];
`else
    logic unused_byte_lsb;
    assign unused_byte_lsb = ^addr_i[WORD_LSB-1:0];
    assign align_fault_o   = 1'b0;
`endif

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller for a single-port read-first word BRAM; optional alignment check via MEM_ALIGN_CHECK_EN.
// Latency fault 1 / store 2 / load 3 edges; one request in flight, req_ready only in IDLE, response has no backpressure.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rstn,
    mem_access_ctrl_if.slave      bus,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [BYTE_ADR_W-1:0] ram_addr,
    output logic [DATA_W-1:0]     ram_di,
    input  logic [DATA_W-1:0]     ram_dout,
    output logic [DATA_W-1:0]     load_cnt,
    output logic [DATA_W-1:0]     store_cnt
);

    mem_state_e            state_q;
    logic                  ram_en_q;
    logic                  ram_we_q;
    logic [BYTE_ADR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0]     ram_di_q;
    logic                  resp_valid_q;
    logic                  resp_fault_q;
    logic [DATA_W-1:0]     resp_rdata_q;
    logic [DATA_W-1:0]     load_cnt_q;
    logic [DATA_W-1:0]     store_cnt_q;

    logic [DATA_W-1:0]     load_cnt_d;
    logic [DATA_W-1:0]     store_cnt_d;
    logic [BYTE_ADR_W-1:0] ram_addr_d;

    logic [ADDR_W-1:0]     word_idx;
    logic                  range_fault;
    logic                  align_fault;
    logic                  req_fault;
    logic                  accept;

    mem_addr_check #(
        .ADDR_W (ADDR_W)
    ) u_addr_check (
        .addr_i        (bus.req_addr),
        .word_idx_o    (word_idx),
        .range_fault_o (range_fault),
        .align_fault_o (align_fault)
    );

    assign req_fault   = range_fault || align_fault;
    assign bus.req_ready = rstn && (state_q == IDLE);
    assign accept      = bus.req_valid && bus.req_ready;
    assign ram_addr_d  = BYTE_ADR_W'(word_idx);
    assign load_cnt_d  = cnt_inc(load_cnt_q);
    assign store_cnt_d = cnt_inc(store_cnt_q);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_di_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= '0;
            load_cnt_q   <= '0;
            store_cnt_q  <= '0;
        end else begin
            // Pulses default low; only the branch producing them raises them for one cycle.
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (req_fault) begin
                            resp_valid_q <= 1'b1;
                            resp_fault_q <= 1'b1;
                            resp_rdata_q <= '0;
                        end else begin
                            ram_addr_q <= ram_addr_d;
                            ram_di_q   <= bus.req_wdata;
                            ram_we_q   <= bus.req_we;
                            ram_en_q   <= 1'b1;
                            state_q    <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    // ram_we_q still holds the accepted request's direction here.
                    if (ram_we_q) begin
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= '0;
                        store_cnt_q  <= store_cnt_d;
                        state_q      <= IDLE;
                    end else begin
                        state_q <= RDWAIT;
                    end
                end
                RDWAIT: begin
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= ram_dout;
                    load_cnt_q   <= load_cnt_d;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ram_en         = ram_en_q;
    assign ram_we         = ram_we_q;
    assign ram_addr       = ram_addr_q;
    assign ram_di         = ram_di_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_fault = resp_fault_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign load_cnt       = load_cnt_q;
    assign store_cnt      = store_cnt_q;

endmodule
